// File: rtl/ram2_ctrl.sv
// ram2_ctrl -- initiator side of the RAM2 interface.
//
// Arbitrates instruction fetches (IF) and data accesses (MEM) onto one
// external asynchronous SRAM. If both sides request in the same idle cycle,
// MEM is serviced first. Every SRAM strobe is a flop output, so the strobes
// cannot glitch. The shared data bus is driven only during the three write
// states. Output enable is low only in RD, so the controller never drives the
// bus while the SRAM does.
//
// Ports
//   clk, rst          system clock; asynchronous active-low reset
//   if_req_i/if_addr_i  fetch request and word address (held until inst_valid_o)
//   inst_o/inst_valid_o fetched word and its one-cycle valid pulse
//   mem_ce_i/re_i/we_i  MEM access enable and op; a write wins over a read
//   mem_addr_i/data_i   MEM word address and write data
//   mem_data_o/done_o   MEM read data and one-cycle completion pulse
//   stall_req_o         combinational stall while a MEM access is in flight
//   ram2_*              SRAM address, tri-state data bus, active-low strobes
module ram2_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WR_HOLD     = 1     // 1..3 cycles of we_n low
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req_i,
  input  logic [ADDR_W-1:0]      if_addr_i,
  output logic [DATA_W-1:0]      inst_o,
  output logic                   inst_valid_o,
  input  logic                   mem_ce_i,
  input  logic                   mem_re_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic [DATA_W-1:0]      mem_data_i,
  output logic [DATA_W-1:0]      mem_data_o,
  output logic                   mem_done_o,
  output logic                   stall_req_o,
  output logic [SRAM_ADDR_W-1:0] ram2_addr_o,
  inout  wire  [DATA_W-1:0]      ram2_data_io,
  output logic                   ram2_en_n,
  output logic                   ram2_oe_n,
  output logic                   ram2_we_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_RECOV = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        hold_cnt;
  logic              is_mem_q;   // current access came from MEM (else fetch)
  logic              drive_q;    // controller owns the data bus
  logic [DATA_W-1:0] wdata_q;
  logic              mem_req;
  logic              accept;

  assign mem_req = mem_ce_i & (mem_re_i | mem_we_i);
  assign accept  = (state_q == S_IDLE) & (mem_req | if_req_i);

  // The stall must be high in the accept cycle itself, so it cannot wait for
  // the state register. It drops in DONE, when the pipeline advances.
  assign stall_req_o = rst & mem_req & (state_q != S_DONE);

  assign ram2_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};

  // NOTE: every variable gets a default before the case. A path that leaves
  // a variable unassigned in combinational logic infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req)       state_d = mem_we_i ? S_WR_SETUP : S_RD;
        else if (if_req_i) state_d = S_RD;
      end
      S_RD:       state_d = S_DONE;
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: if (hold_cnt == 2'd0) state_d = S_WR_RECOV;
      S_WR_RECOV: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The strobes and pulses are computed from the next state. Each output
  // therefore changes on the same edge as the state it belongs to.
  // NOTE: non-blocking assignments let every flop sample pre-edge values.
  // Blocking assignments here would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hold_cnt     <= 2'd0;
      is_mem_q     <= 1'b0;
      drive_q      <= 1'b0;
      wdata_q      <= '0;
      ram2_addr_o  <= '0;
      ram2_en_n    <= 1'b1;
      ram2_oe_n    <= 1'b1;
      ram2_we_n    <= 1'b1;
      inst_o       <= '0;
      mem_data_o   <= '0;
      inst_valid_o <= 1'b0;
      mem_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram2_en_n    <= !((state_d == S_RD) || (state_d == S_WR_SETUP) ||
                        (state_d == S_WR_PULSE) || (state_d == S_WR_RECOV));
      ram2_oe_n    <= (state_d != S_RD);
      ram2_we_n    <= (state_d != S_WR_PULSE);
      drive_q      <= (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                      (state_d == S_WR_RECOV);
      inst_valid_o <= (state_d == S_DONE) && !is_mem_q;
      mem_done_o   <= (state_d == S_DONE) && is_mem_q;

      // The request is captured once. Later input changes are ignored until
      // the access completes.
      if (accept) begin
        is_mem_q    <= mem_req;
        wdata_q     <= mem_data_i;
        ram2_addr_o <= SRAM_ADDR_W'(mem_req ? mem_addr_i : if_addr_i);
      end

      // Down-counter for the write pulse width.
      if (state_q == S_WR_SETUP)
        hold_cnt <= 2'(WR_HOLD - 1);
      else if ((state_q == S_WR_PULSE) && (hold_cnt != 2'd0))
        hold_cnt <= hold_cnt - 2'd1;

      // The SRAM has had the whole RD cycle to settle. Sample its data on the
      // edge that ends RD.
      if (state_q == S_RD) begin
        if (is_mem_q) mem_data_o <= ram2_data_io;
        else          inst_o     <= ram2_data_io;
      end
    end
  end

endmodule
